y86_dmem_responder: RTL and testbench

//   Data-memory responder for the Y86-64 core: the memory-side end of the load/store path.

---
 rtl/y86_dmem_responder_if.sv | 24 ++
 rtl/y86_dmem_responder.sv | 133 +++++++++++++
 tb/tb_y86_dmem_responder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_dmem_responder_if.sv
// Load/store bus between the Y86-64 core (master) and its data memory (slave).
// A valid/ready request channel carries one 8-byte access.
// A valid/ready response channel returns load data and a Y86 status code.
interface y86_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [2:0]  rsp_stat;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_stat
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_stat
    );
endinterface

// File: rtl/y86_dmem_responder.sv
// Data-memory responder for the Y86-64 core.
// Accepts one 64-bit load or store at a time, waits WAIT_CYCLES, performs the
// access on a little-endian byte array and returns data plus AOK/ADR status.
// The byte array is deliberately not reset, so memory contents survive rst_n.
module y86_dmem_responder #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    y86_dmem_responder_if.slave  bus
);

    localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] LAST_OK   = 64'(MEM_BYTES - 8);
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
    localparam logic [2:0]  STAT_AOK  = 3'd1;
    localparam logic [2:0]  STAT_ADR  = 3'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [7:0]  count;
    logic        lat_write;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_rdata_q;
    logic [2:0]  rsp_stat_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        accept;
    logic        access;
    logic        acc_write;
    logic        acc_err;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [63:0] rd_word;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_stat  = rsp_stat_q;

    assign accept = (state == IDLE) && bus.req_valid && req_ready_q;

    // Pick the access operands: live request for zero-wait accesses, latched copy otherwise
    always_comb begin
        access    = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (count == 8'd1));
        acc_write = (state == IDLE) ? bus.req_write : lat_write;
        acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
        acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
        acc_err   = (acc_addr > LAST_OK);
        acc_idx   = acc_addr[AW-1:0];
    end

    // Assemble the little-endian load word from eight consecutive bytes
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem[acc_idx + AW'(i)];
        end
    end

    // Commit an in-range store into the byte array on its access edge
    always_ff @(posedge clk) begin
        if (access && acc_write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                mem[acc_idx + AW'(i)] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 8'd0;
            lat_write   <= 1'b0;
            lat_addr    <= 64'd0;
            lat_wdata   <= 64'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_stat_q  <= STAT_AOK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write   <= bus.req_write;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        count       <= WAIT_INIT;
                        req_ready_q <= 1'b0;
                        if (access) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= (acc_err || acc_write) ? 64'd0 : rd_word;
                            rsp_stat_q  <= acc_err ? STAT_ADR : STAT_AOK;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    count <= count - 8'd1;
                    if (access) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (acc_err || acc_write) ? 64'd0 : rd_word;
                        rsp_stat_q  <= acc_err ? STAT_ADR : STAT_AOK;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Self-checking bench for y86_dmem_responder.
// Two instances: a 1 KiB memory with three wait states and a 64-byte memory
// with no wait states. A byte-array model predicts every response; predictions
// are queued at request time and compared when each response handshakes.
module tb_y86_dmem_responder;

    localparam int MEM0 = 1024;
    localparam int W0   = 3;
    localparam int MEM1 = 64;
    localparam int W1   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    y86_dmem_responder_if bus0 ();
    y86_dmem_responder_if bus1 ();

    y86_dmem_responder #(.MEM_BYTES(MEM0), .WAIT_CYCLES(W0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    y86_dmem_responder #(.MEM_BYTES(MEM1), .WAIT_CYCLES(W1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic        drv_valid  [2] = '{1'b0, 1'b0};
    logic        drv_write  [2] = '{1'b0, 1'b0};
    logic        drv_rready [2] = '{1'b0, 1'b0};
    logic [63:0] drv_addr   [2] = '{64'd0, 64'd0};
    logic [63:0] drv_wdata  [2] = '{64'd0, 64'd0};

    logic        obs_req_ready [2];
    logic        obs_rsp_valid [2];
    logic [63:0] obs_rdata     [2];
    logic [2:0]  obs_stat      [2];

    assign bus0.req_valid = drv_valid[0];
    assign bus0.req_write = drv_write[0];
    assign bus0.req_addr  = drv_addr[0];
    assign bus0.req_wdata = drv_wdata[0];
    assign bus0.rsp_ready = drv_rready[0];
    assign bus1.req_valid = drv_valid[1];
    assign bus1.req_write = drv_write[1];
    assign bus1.req_addr  = drv_addr[1];
    assign bus1.req_wdata = drv_wdata[1];
    assign bus1.rsp_ready = drv_rready[1];

    assign obs_req_ready[0] = bus0.req_ready;
    assign obs_rsp_valid[0] = bus0.rsp_valid;
    assign obs_rdata[0]     = bus0.rsp_rdata;
    assign obs_stat[0]      = bus0.rsp_stat;
    assign obs_req_ready[1] = bus1.req_ready;
    assign obs_rsp_valid[1] = bus1.rsp_valid;
    assign obs_rdata[1]     = bus1.rsp_rdata;
    assign obs_stat[1]      = bus1.rsp_stat;

    logic [7:0]  model0 [MEM0];
    logic [7:0]  model1 [MEM1];
    logic [66:0] exp_q0 [$];
    logic [66:0] exp_q1 [$];
    logic [66:0] mon_exp;

    int compared   = 0;
    int mismatched = 0;

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [66:0] observed, input logic [66:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: returns {stat, rdata} and applies in-range stores
    function automatic logic [66:0] modelAccess(input int sel, input logic wr,
                                                input logic [63:0] addr, input logic [63:0] wdata);
        logic [63:0] rd;
        int size;
        int base;
        size = (sel == 0) ? MEM0 : MEM1;
        if (addr > 64'(size - 8)) return {3'd3, 64'd0};
        base = int'(addr[31:0]);
        rd   = '0;
        for (int i = 0; i < 8; i++) begin
            if (wr) begin
                if (sel == 0) model0[base + i] = wdata[8*i +: 8];
                else          model1[base + i] = wdata[8*i +: 8];
            end else begin
                if (sel == 0) rd[8*i +: 8] = model0[base + i];
                else          rd[8*i +: 8] = model1[base + i];
            end
        end
        return wr ? {3'd1, 64'd0} : {3'd1, rd};
    endfunction

    task automatic pushExp(input int sel, input logic [66:0] e);
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    // Scoreboard: a response completes on the posedge after a negedge with valid && ready
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (obs_rsp_valid[s] && drv_rready[s]) begin
                    if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
                        checkOutput((s == 0) ? "unexpected_rsp0" : "unexpected_rsp1", 67'd1, 67'd0);
                    end else begin
                        mon_exp = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        checkOutput((s == 0) ? "rsp0" : "rsp1", {obs_stat[s], obs_rdata[s]}, mon_exp);
                    end
                end
            end
        end
    end

    task automatic checkResetValues(input int sel, input string tag);
        checkOutput({tag, "_req_ready"}, 67'(obs_req_ready[sel]), 67'd0);
        checkOutput({tag, "_rsp_valid"}, 67'(obs_rsp_valid[sel]), 67'd0);
        checkOutput({tag, "_rsp_word"}, {obs_stat[sel], obs_rdata[sel]}, {3'd1, 64'd0});
    endtask

    // One complete transaction: request, latency check, optional backpressure, handshake
    task automatic applyStimulus(input int sel, input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input int hold);
        logic [66:0] e;
        int n;
        int lat;
        e = modelAccess(sel, wr, addr, wdata);
        pushExp(sel, e);
        drv_write[sel] = wr;
        drv_addr[sel]  = addr;
        drv_wdata[sel] = wdata;
        drv_valid[sel] = 1'b1;
        n = 0;
        while (!obs_req_ready[sel] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checkOutput("accept_timeout", 67'd0, 67'd1);
            drv_valid[sel] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        drv_valid[sel] = 1'b0;
        drv_write[sel] = ~wr;
        drv_addr[sel]  = 64'h5555_AAAA_5555_AAAA;
        drv_wdata[sel] = 64'hBAD0_BAD0_BAD0_BAD0;
        checkOutput("req_ready_busy", 67'(obs_req_ready[sel]), 67'd0);
        lat = 0;
        while (!obs_rsp_valid[sel] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", 67'(lat), 67'((sel == 0) ? W0 : W1));
        if (lat >= 300) return;
        for (int k = 0; k < hold; k++) begin
            checkOutput("hold_valid", 67'(obs_rsp_valid[sel]), 67'd1);
            checkOutput("hold_word", {obs_stat[sel], obs_rdata[sel]}, e);
            checkOutput("hold_req_ready", 67'(obs_req_ready[sel]), 67'd0);
            @(posedge clk); #1;
        end
        drv_rready[sel] = 1'b1;
        @(posedge clk); #1;
        drv_rready[sel] = 1'b0;
        checkOutput("rsp_valid_drop", 67'(obs_rsp_valid[sel]), 67'd0);
        checkOutput("req_ready_back", 67'(obs_req_ready[sel]), 67'd1);
    endtask

    // Four alternating requests with req_valid held high and rsp_ready held high
    task automatic backToBack();
        logic        wr_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] addr_t [4] = '{64'h40, 64'h40, 64'h48, 64'h48};
        logic [63:0] data_t [4] = '{64'hA5A5_0101_5A5A_0202, 64'd0, 64'hFEED_FACE_0BAD_F00D, 64'd0};
        logic [66:0] e;
        logic will_accept;
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        drv_rready[0] = 1'b1;
        drv_write[0]  = wr_t[0];
        drv_addr[0]   = addr_t[0];
        drv_wdata[0]  = data_t[0];
        drv_valid[0]  = 1'b1;
        while (idx < 4 && cyc < 200) begin
            @(negedge clk);
            will_accept = obs_req_ready[0];
            if (will_accept) checkOutput("ready_only_idle", 67'(obs_rsp_valid[0]), 67'd0);
            @(posedge clk); #1;
            cyc++;
            if (will_accept) begin
                e = modelAccess(0, wr_t[idx], addr_t[idx], data_t[idx]);
                pushExp(0, e);
                idx++;
                if (idx < 4) begin
                    drv_write[0] = wr_t[idx];
                    drv_addr[0]  = addr_t[idx];
                    drv_wdata[0] = data_t[idx];
                end else begin
                    drv_valid[0] = 1'b0;
                end
            end
        end
        checkOutput("b2b_accepted", 67'(idx), 67'd4);
        drv_valid[0] = 1'b0;
        cyc = 0;
        while (exp_q0.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("b2b_drained", 67'(exp_q0.size()), 67'd0);
        @(posedge clk); #1;
        drv_rready[0] = 1'b0;
    endtask

    // Store gets accepted, then reset hits while it is still waiting
    task automatic abortedStore();
        int n;
        drv_write[0] = 1'b1;
        drv_addr[0]  = 64'h20;
        drv_wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        drv_valid[0] = 1'b1;
        n = 0;
        while (!obs_req_ready[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_ready", 67'(obs_req_ready[0]), 67'd1);
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_in_wait", 67'(obs_rsp_valid[0]), 67'd0);
        rst_n = 1'b0;
        #1;
        checkResetValues(0, "abort_rst_a");
        repeat (2) @(posedge clk);
        #1;
        checkResetValues(0, "abort_rst_b");
        checkResetValues(1, "abort_rst_c");
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("abort_no_rsp", 67'(obs_rsp_valid[0]), 67'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEM0; i++) model0[i] = 8'h00;
        for (int i = 0; i < MEM1; i++) model1[i] = 8'h00;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues(0, "rst0");
        checkResetValues(1, "rst1");
        rst_n = 1'b1;
        checkOutput("ready_after_release", 67'(obs_req_ready[0]), 67'd0);
        @(posedge clk); #1;
        checkOutput("ready_first_clk", 67'(obs_req_ready[0]), 67'd1);

        // Basic store/load and little-endian byte view
        applyStimulus(0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 0);
        applyStimulus(0, 1'b0, 64'h10, 64'd0, 0);
        applyStimulus(0, 1'b1, 64'h18, 64'd0, 0);
        applyStimulus(0, 1'b0, 64'h11, 64'd0, 0);
        applyStimulus(0, 1'b0, 64'h17, 64'd0, 0);

        // Top-of-memory boundary with backpressure on the load
        applyStimulus(0, 1'b1, 64'(MEM0 - 8), 64'hDEAD_BEEF_CAFE_F00D, 0);
        applyStimulus(0, 1'b0, 64'(MEM0 - 8), 64'd0, 5);
        applyStimulus(0, 1'b1, 64'(MEM0 - 7), 64'h1234_1234_1234_1234, 0);
        applyStimulus(0, 1'b0, 64'(MEM0 - 7), 64'd0, 0);
        applyStimulus(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h7777_7777_7777_7777, 0);
        applyStimulus(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0);
        applyStimulus(0, 1'b0, 64'(MEM0 - 8), 64'd0, 0);

        // Zero-wait instance
        applyStimulus(1, 1'b1, 64'(MEM1 - 8), 64'h0F0E_0D0C_0B0A_0908, 0);
        applyStimulus(1, 1'b0, 64'(MEM1 - 8), 64'd0, 0);
        applyStimulus(1, 1'b0, 64'(MEM1 - 7), 64'd0, 0);
        applyStimulus(1, 1'b1, 64'h0, 64'h1122_3344_5566_7788, 0);
        applyStimulus(1, 1'b0, 64'h0, 64'd0, 2);

        // Reset in the middle of a store leaves the old value in memory
        applyStimulus(0, 1'b1, 64'h20, 64'h1111, 0);
        abortedStore();
        applyStimulus(0, 1'b0, 64'h20, 64'd0, 0);

        backToBack();

        checkOutput("queue0_empty", 67'(exp_q0.size()), 67'd0);
        checkOutput("queue1_empty", 67'(exp_q1.size()), 67'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
